// File: rtl/rr_sel_arbiter.sv
// Four-source round-robin arbiter driving a registered 2-bit mux select.
// Each grant is held until the owner finishes, drops its request, or hits MAX_HOLD cycles.
module rr_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [3:0] req_in,
    input  logic       done_in,
    output logic [1:0] sel_out,
    output logic [3:0] grant_out,
    output logic       valid_out,
    output logic       preempt_out
);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    grant_q, grant_d;
    logic          valid_q, valid_d;
    logic          pre_q, pre_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic          owner_req;
    logic          at_limit;
    logic          release_now;

    // Search starts at the pointer and wraps, so the last owner goes to the back of the line.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && req_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req   = req_in[sel_q];
    assign at_limit    = (cnt_q == CNT_LAST);
    assign release_now = done_in || !owner_req || at_limit;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        pre_d   = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                    // Preemption only when the limit alone forced the release.
                    pre_d   = at_limit && !done_in && owner_req;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            pre_q   <= 1'b0;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            pre_q   <= pre_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_out     = sel_q;
    assign grant_out   = grant_q;
    assign valid_out   = valid_q;
    assign preempt_out = pre_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: vector table, directed corner sequences, and a
// per-cycle scoreboard against a grant-age model for MAX_HOLD = 8 and MAX_HOLD = 1.
module tb_rr_sel_arbiter;
    localparam int HOLD_A = 8;
    localparam int HOLD_B = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;

    logic [1:0] sel_a, sel_b;
    logic [3:0] grant_a, grant_b;
    logic       valid_a, valid_b, pre_a, pre_b;

    int checks = 0;
    int failures = 0;
    bit sb_en = 1'b0;

    rr_sel_arbiter #(.MAX_HOLD(HOLD_A)) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .done_in(done),
        .sel_out(sel_a), .grant_out(grant_a), .valid_out(valid_a), .preempt_out(pre_a)
    );
    rr_sel_arbiter #(.MAX_HOLD(HOLD_B)) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .done_in(done),
        .sel_out(sel_b), .grant_out(grant_b), .valid_out(valid_b), .preempt_out(pre_b)
    );

    always #5 clk = ~clk;

    // Model: index 0 tracks HOLD_A, index 1 tracks HOLD_B. m_age counts valid cycles seen.
    bit m_busy[2];
    int m_owner[2];
    int m_age[2];
    int m_ptr[2];
    bit m_pre[2];
    int w;
    int idx;
    int lim;
    bit drop, hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_owner[i] = 0; m_age[i] = 0; m_ptr[i] = 0; m_pre[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                lim = (i == 0) ? HOLD_A : HOLD_B;
                m_pre[i] = 0;
                if (!m_busy[i]) begin
                    w = -1;
                    for (int k = 0; k < 4; k++) begin
                        idx = (m_ptr[i] + k) % 4;
                        if (w < 0 && req[idx]) w = idx;
                    end
                    if (w >= 0) begin
                        m_busy[i] = 1; m_owner[i] = w; m_age[i] = 1;
                    end
                end else begin
                    drop = !req[m_owner[i]];
                    hit  = (m_age[i] >= lim);
                    if (done || drop || hit) begin
                        m_busy[i] = 0;
                        m_ptr[i]  = (m_owner[i] + 1) % 4;
                        m_pre[i]  = hit && !done && !drop;
                    end else begin
                        m_age[i] = m_age[i] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            chk("sb_a_valid", int'(valid_a), int'(m_busy[0]));
            chk("sb_a_sel",   int'(sel_a),   m_owner[0]);
            chk("sb_a_grant", int'(grant_a), m_busy[0] ? (1 << m_owner[0]) : 0);
            chk("sb_a_pre",   int'(pre_a),   int'(m_pre[0]));
            chk("sb_b_valid", int'(valid_b), int'(m_busy[1]));
            chk("sb_b_sel",   int'(sel_b),   m_owner[1]);
            chk("sb_b_grant", int'(grant_b), m_busy[1] ? (1 << m_owner[1]) : 0);
            chk("sb_b_pre",   int'(pre_b),   int'(m_pre[1]));
        end
    end

    task automatic step(input logic [3:0] r, input logic d);
        req = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input int s, input int g, input int v, input int p);
        chk({tag, "_sel"},   int'(sel_a),   s);
        chk({tag, "_grant"}, int'(grant_a), g);
        chk({tag, "_valid"}, int'(valid_a), v);
        chk({tag, "_pre"},   int'(pre_a),   p);
    endtask

    task automatic expect_zero(input string tag);
        expect_a(tag, 0, 0, 0, 0);
        chk({tag, "_b_valid"}, int'(valid_b), 0);
        chk({tag, "_b_grant"}, int'(grant_b), 0);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        done = 1'b0;
        rst_n = 1'b0;
        #2;
        expect_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t tbl[17];

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[8]  = '{4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1};
        tbl[9]  = '{4'b0011, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        tbl[10] = '{4'b0011, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[12] = '{4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[14] = '{4'b0011, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[15] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[16] = '{4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0};

        #1;
        expect_zero("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_en = 1'b1;

        // Hold limit, pointer advance, wrap/skip, done ignored in IDLE
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req, tbl[i].done);
            expect_a($sformatf("tbl%0d", i), int'(tbl[i].sel), int'(tbl[i].grant),
                     int'(tbl[i].valid), int'(tbl[i].pre));
        end

        // Rotation with done on the second grant cycle
        do_reset();
        for (int g = 0; g < 5; g++) begin
            step(4'b1111, 1'b0);
            expect_a($sformatf("rot%0d_c1", g), g % 4, 1 << (g % 4), 1, 0);
            step(4'b1111, 1'b0);
            expect_a($sformatf("rot%0d_c2", g), g % 4, 1 << (g % 4), 1, 0);
            step(4'b1111, 1'b1);
            expect_a($sformatf("rot%0d_idle", g), g % 4, 0, 0, 0);
        end

        // Owner drops its request on the third grant cycle
        do_reset();
        step(4'b0010, 1'b0);
        expect_a("drop_c1", 1, 4'b0010, 1, 0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        expect_a("drop_c3", 1, 4'b0010, 1, 0);
        step(4'b0000, 1'b0);
        expect_a("drop_rel", 1, 0, 0, 0);
        step(4'b0110, 1'b0);
        expect_a("drop_ptr2", 2, 4'b0100, 1, 0);

        // done coincides with the hold limit
        for (int c = 0; c < 7; c++) step(4'b0110, 1'b0);
        expect_a("sim_c8", 2, 4'b0100, 1, 0);
        step(4'b0110, 1'b1);
        expect_a("sim_rel", 2, 0, 0, 0);
        step(4'b0000, 1'b0);
        expect_a("sim_idle", 2, 0, 0, 0);

        // Asynchronous reset during a grant to source 2
        step(4'b0100, 1'b0);
        expect_a("rst_grant", 2, 4'b0100, 1, 0);
        step(4'b0100, 1'b0);
        rst_n = 1'b0;
        #2;
        expect_zero("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0100, 1'b0);
        expect_a("rst_regrant", 2, 4'b0100, 1, 0);
        step(4'b0100, 1'b1);
        expect_a("rst_rel", 2, 0, 0, 0);
        step(4'b0101, 1'b0);
        expect_a("rst_wrap0", 0, 4'b0001, 1, 0);
        step(4'b0101, 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end

        sb_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
